// File: rtl/ysyx_22040632_div_ctrl.sv
// Sequencer between the EXU and the iterative divider: short-circuits divide-by-zero and signed
// overflow, issues all other ops, holds the result until taken. Optional result cache: DIV_CTRL_CACHE_EN.
module ysyx_22040632_div_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rrst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic            req_w,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  input  logic            flush,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            div_valid,
  input  logic            div_ready,
  output logic            div_signed,
  output logic            divw,
  output logic [XLEN-1:0] dividend,
  output logic [XLEN-1:0] divisor,
  output logic            div_flush,
  input  logic            out_valid,
  input  logic [XLEN-1:0] quotient,
  input  logic [XLEN-1:0] remainder
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

  state_t          state, state_n;
  logic [1:0]      op_q;
  logic            w_q;
  logic [XLEN-1:0] src1_q, src2_q;
  logic            rsp_load;
  logic [XLEN-1:0] rsp_next;
  logic            accept;
  logic            cache_hit;
  logic [XLEN-1:0] cache_data;
  logic            cache_fill;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v, input logic w);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Shortcut detection works on the raw request so the answer is ready at accept.
  logic            req_signed, req_rem, div_zero, div_ovf;
  logic [XLEN-1:0] short_data, cap_data;
  logic [XLEN-1:0] most_neg;

  assign most_neg   = {1'b1, {(XLEN-1){1'b0}}};
  assign req_signed = ~req_op[0];
  assign req_rem    = req_op[1];
  assign div_zero   = req_w ? (req_src2[31:0] == 32'h0) : (req_src2 == '0);
  assign div_ovf    = req_signed & (req_w ? (req_src1[31:0] == 32'h8000_0000 && req_src2[31:0] == 32'hFFFF_FFFF)
                                          : (req_src1 == most_neg && req_src2 == '1));
  assign short_data = req_rem ? sext_w(div_zero ? req_src1 : '0, req_w)
                              : sext_w(div_zero ? '1 : req_src1, req_w);
  assign cap_data   = sext_w(op_q[1] ? remainder : quotient, w_q);

  assign accept     = (state == S_IDLE) && req_valid && !flush;
  assign cache_fill = (state == S_WAIT) && !flush && out_valid;

  assign div_signed = ~op_q[0];
  assign divw       = w_q;
  assign dividend   = src1_q;
  assign divisor    = src2_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state    <= S_IDLE;
      op_q     <= 2'b00;
      w_q      <= 1'b0;
      src1_q   <= '0;
      src2_q   <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q   <= req_op;
        w_q    <= req_w;
        src1_q <= req_src1;
        src2_q <= req_src2;
      end
      if (rsp_load) rsp_data <= rsp_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    rsp_load  = 1'b0;
    rsp_next  = rsp_data;
    div_valid = 1'b0;
    div_flush = 1'b0;
    req_ready = (state == S_IDLE);
    rsp_valid = (state == S_RESP);
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (div_zero || div_ovf) begin
            rsp_load = 1'b1;
            rsp_next = short_data;
            state_n  = S_RESP;
          end else if (cache_hit) begin
            rsp_load = 1'b1;
            rsp_next = cache_data;
            state_n  = S_RESP;
          end else begin
            state_n  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (flush) begin
          div_flush = 1'b1;
          state_n   = S_DRAIN;
        end else if (div_ready) begin
          div_valid = 1'b1;
          state_n   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          div_flush = 1'b1;
          state_n   = S_DRAIN;
        end else if (out_valid) begin
          rsp_load = 1'b1;
          rsp_next = cap_data;
          state_n  = S_RESP;
        end
      end
      S_RESP: begin
        if (flush || rsp_ready) state_n = S_IDLE;
      end
      S_DRAIN: begin
        // A late done pulse from the killed op must not leak into the next one.
        if (div_ready && !out_valid) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

`ifdef DIV_CTRL_CACHE_EN
  logic            cache_valid;
  logic            c_signed, c_w;
  logic [XLEN-1:0] c_src1, c_src2, c_quo, c_rem;

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n)         cache_valid <= 1'b0;
    else if (cache_fill) cache_valid <= 1'b1;
  end

  // NOTE: payload storage has no reset; cache_valid alone guards it.
  always_ff @(posedge clk) begin
    if (cache_fill) begin
      c_src1   <= src1_q;
      c_src2   <= src2_q;
      c_signed <= ~op_q[0];
      c_w      <= w_q;
      c_quo    <= quotient;
      c_rem    <= remainder;
    end
  end

  assign cache_hit  = cache_valid && c_src1 == req_src1 && c_src2 == req_src2 &&
                      c_signed == req_signed && c_w == req_w;
  assign cache_data = sext_w(req_rem ? c_rem : c_quo, req_w);
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  a_out_valid_window: assert property (@(posedge clk) disable iff (!rrst_n)
    out_valid |-> (state == S_WAIT || state == S_DRAIN));

endmodule

// File: tb/tb_ysyx_22040632_div_ctrl.sv
// Directed bench for ysyx_22040632_div_ctrl with a behavioural divider and a result scoreboard.
module tb_ysyx_22040632_div_ctrl;

  localparam int XLEN = 64;
  localparam int LAT  = 20;
`ifdef DIV_CTRL_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

  logic            clk = 1'b0;
  logic            rrst_n;
  logic            req_valid, req_ready, req_w;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_src1, req_src2;
  logic            flush;
  logic            rsp_valid, rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            div_valid, div_ready, div_signed, divw, div_flush;
  logic [XLEN-1:0] dividend, divisor;
  logic            out_valid;
  logic [XLEN-1:0] quotient, remainder;

  int total = 0;
  int bad   = 0;
  int starts = 0;
  logic [63:0] sb[$];

  ysyx_22040632_div_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rrst_n(rrst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_w(req_w),
    .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .div_valid(div_valid), .div_ready(div_ready), .div_signed(div_signed), .divw(divw),
    .dividend(dividend), .divisor(divisor), .div_flush(div_flush),
    .out_valid(out_valid), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  // Behavioural divider: fixed latency, word results zero-extended, 3-cycle recovery after flush.
  logic [63:0] m_a, m_b;
  logic        m_s, m_w, m_busy;
  int          m_cnt, m_rec;

  function automatic logic [63:0] model_div(input logic [63:0] a, b, input logic s, w, input bit rem);
    logic [31:0] a32, b32;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (s) return rem ? {32'h0, 32'($signed(a32) % $signed(b32))} : {32'h0, 32'($signed(a32) / $signed(b32))};
      return rem ? {32'h0, a32 % b32} : {32'h0, a32 / b32};
    end
    if (s) return rem ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
    return rem ? a % b : a / b;
  endfunction

  always @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      m_busy <= 1'b0; m_cnt <= 0; m_rec <= 0;
      out_valid <= 1'b0; quotient <= '0; remainder <= '0;
    end else begin
      out_valid <= 1'b0;
      if (div_flush) begin
        m_busy <= 1'b0;
        m_rec  <= 3;
      end else if (m_rec > 0) begin
        m_rec <= m_rec - 1;
      end else if (div_valid && !m_busy) begin
        m_busy <= 1'b1; m_cnt <= LAT;
        m_a <= dividend; m_b <= divisor; m_s <= div_signed; m_w <= divw;
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy    <= 1'b0;
          out_valid <= 1'b1;
          quotient  <= model_div(m_a, m_b, m_s, m_w, 1'b0);
          remainder <= model_div(m_a, m_b, m_s, m_w, 1'b1);
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end
  assign div_ready = !m_busy && (m_rec == 0);

  always @(posedge clk) if (div_valid && div_ready) starts <= starts + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic w, input logic [63:0] a, b,
                      input bit push, input logic [63:0] exp);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_w = w; req_src1 = a; req_src2 = b;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    check("accept", 64'(req_ready), 64'd1);
    if (push) sb.push_back(exp);
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag, input bit fast, input int hold);
    int n = 1;
    logic [63:0] exp, held;
    @(negedge clk);
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    if (fast) check({tag, "_latency"}, 64'(n), 64'd1);
    exp  = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    held = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
      check({tag, "_hold_data"}, rsp_data, held);
    end
    check(tag, rsp_data, exp);
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_drop"}, 64'(rsp_valid), 64'd0);
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic w, input logic [63:0] a, b,
                     input logic [63:0] exp, input bit fast, input int exp_starts, input int hold);
    int s0 = starts;
    send(op, w, a, b, 1'b1, exp);
    get_rsp(tag, fast, hold);
    check({tag, "_starts"}, 64'(starts - s0), 64'(exp_starts));
  endtask

  initial begin
    int n, s0;
    bit rsp_seen;
    rrst_n = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_w = 1'b0;
    req_src1 = '0; req_src2 = '0; flush = 1'b0; rsp_ready = 1'b0;
    #1 rrst_n = 1'b0;
    #2;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_div_valid", 64'(div_valid), 64'd0);
    check("rst_div_flush", 64'(div_flush), 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    repeat (2) @(negedge clk);
    rrst_n = 1'b1;

    run("divu_100_7", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0, 1, 0);
    run("remu_100_7", OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, CACHE, CACHE ? 0 : 1, 0);
    run("div_m7_2", OP_DIV, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1, 0);
    run("rem_m7_2", OP_REM, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, CACHE, CACHE ? 0 : 1, 0);
    run("divw_ovf", OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'hFFFF_FFFF_8000_0000, 1'b1, 0, 0);
    run("remu_5_0", OP_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1'b1, 0, 0);
    run("div_5_0", OP_DIV, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 0);
    run("divuw_sext", OP_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1, 0);
    run("remw_zero", OP_REM, 1'b1, 64'h1234_5678_8000_0001, 64'h0000_0001_0000_0000,
        64'hFFFF_FFFF_8000_0001, 1'b1, 0, 0);
    run("div_ovf64", OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'h8000_0000_0000_0000, 1'b1, 0, 0);
    run("rem_ovf64", OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0, 0);

    // Flush ten cycles into WAIT: divider recovers for three cycles, controller drains.
    s0 = starts;
    send(OP_DIV, 1'b0, 64'd1000, 64'd3, 1'b0, 64'd0);
    n = 0;
    while (starts == s0 && n < 50) begin @(negedge clk); n++; end
    check("flush_issued", 64'(starts - s0), 64'd1);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1 check("flush_pulse", 64'(div_flush), 64'd1);
    @(posedge clk); #1 flush = 1'b0;
    n = 0; rsp_seen = 1'b0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      if (rsp_valid) rsp_seen = 1'b1;
      n++;
      @(negedge clk);
    end
    check("flush_no_rsp", 64'(rsp_seen), 64'd0);
    check("flush_drain_cycles", 64'(n), 64'd4);
    check("flush_div_ready", 64'(div_ready), 64'd1);
    repeat (LAT + 2) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen = 1'b1;
    end
    check("flush_no_late_rsp", 64'(rsp_seen), 64'd0);

    run("div_1000_3", OP_DIV, 1'b0, 64'd1000, 64'd3, 64'd333, 1'b0, 1, 0);
    run("rem_1000_3", OP_REM, 1'b0, 64'd1000, 64'd3, 64'd1, CACHE, CACHE ? 0 : 1, 5);

    // Flush while a response is pending drops it.
    send(OP_DIVU, 1'b0, 64'd9, 64'd3, 1'b0, 64'd0);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    check("resp_flush_valid", 64'(rsp_valid), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("resp_flush_drop", 64'(rsp_valid), 64'd0);
    check("resp_flush_ready", 64'(req_ready), 64'd1);

    // A request coinciding with flush in IDLE is not taken.
    s0 = starts;
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_DIV; req_w = 1'b0; req_src1 = 64'd5; req_src2 = 64'd0; flush = 1'b1;
    @(posedge clk); #1 begin req_valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    check("idle_flush_no_rsp", 64'(rsp_valid), 64'd0);
    check("idle_flush_ready", 64'(req_ready), 64'd1);
    check("idle_flush_starts", 64'(starts - s0), 64'd0);

    // Reset in the middle of a divide.
    s0 = starts;
    send(OP_DIV, 1'b0, 64'd77, 64'd5, 1'b0, 64'd0);
    n = 0;
    while (starts == s0 && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    rrst_n = 1'b0;
    #1;
    check("midrst_ready", 64'(req_ready), 64'd1);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_rsp_data", rsp_data, 64'd0);
    @(negedge clk);
    rrst_n = 1'b1;
    run("divu_77_5", OP_DIVU, 1'b0, 64'd77, 64'd5, 64'd15, 1'b0, 1, 0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
